// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_arbiter_pkg
// Brief   : Shared widths, FSM state and owner-tag encodings for the
//           instruction-memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package imem_arbiter_pkg;

    localparam int IMEM_AW       = 8;   // matches the 8-bit PC
    localparam int IMEM_DW       = 8;   // matches INST
    localparam int IMEM_MAX_LOCK = 16;  // default locked-grant limit
    localparam int LOCK_CNT_W    = 5;   // starvation-guard counter width

    // Last owner of the memory port; LOCK means the loader holds a burst lock.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_LDR  = 2'd2,
        ST_LOCK = 2'd3
    } arb_state_t;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_LDR  = 2'd2
    } owner_tag_t;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_arbiter_if
// Brief   : Fetch, loader and memory-side signals of the instruction-memory
//           arbiter. slave = arbiter side, master = requesters + memory side.
// Rev     : 1.0  initial release
// ============================================================================
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
);
    // Fetch path
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_stall;
    // Loader / debug port
    logic          ldr_req;
    logic          ldr_we;
    logic          ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_rvalid;
    // Single-port synchronous memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, ldr_req, ldr_we, ldr_lock, ldr_addr,
               ldr_wdata, mem_rdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall, ldr_gnt,
               ldr_rdata, ldr_rvalid, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_addr, ldr_req, ldr_we, ldr_lock, ldr_addr,
               ldr_wdata, mem_rdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall, ldr_gnt,
               ldr_rdata, ldr_rvalid, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imem_arbiter
// Brief   : Round-robin arbiter sharing a single-port 256x8 instruction
//           memory between CPU fetch and a loader/debug port, with loader
//           burst lock and one-cycle read return.
//           Build option IMEM_ARB_STARVE_GUARD_EN: forces a pending fetch
//           through after MAX_LOCK consecutive locked loader grants.
// Rev     : 1.0  initial release
// ============================================================================
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int AW       = IMEM_AW,
    parameter int DW       = IMEM_DW,
    parameter int MAX_LOCK = IMEM_MAX_LOCK
)(
    input  logic            CLK,
    input  logic            CLB,
    imem_arbiter_if.slave   bus
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    owner_tag_t    r_tag;
    owner_tag_t    w_tag_nxt;
    logic          w_cpu_gnt;
    logic          w_ldr_gnt;
    logic          w_force_cpu;
    logic          w_cpu_rvalid;
    logic          w_ldr_rvalid;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ldr_rdata;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam logic [LOCK_CNT_W-1:0] c_MAX_LOCK = LOCK_CNT_W'(MAX_LOCK);

    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;

    // A waiting fetch wins once the loader has held the lock long enough.
    assign w_force_cpu = (r_state == ST_LOCK) & bus.ldr_req & bus.cpu_req
                       & (r_lock_cnt >= c_MAX_LOCK);

    // Count locked loader grants made while a fetch is waiting.
    always_comb begin
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_cpu_gnt || (w_state_nxt != ST_LOCK)) begin
            w_lock_cnt_nxt = '0;
        end else if (w_ldr_gnt && bus.ldr_lock && bus.cpu_req) begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
    end

    // Lock counter register.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            r_lock_cnt <= '0;
        end else begin
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end
`else
    logic w_unused_cfg;

    assign w_force_cpu  = 1'b0;
    assign w_unused_cfg = (MAX_LOCK != 0);
`endif

    // Grant decision: lock wins, otherwise round-robin against the last owner.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (!CLB) begin
            if ((r_state == ST_LOCK) && bus.ldr_req && !w_force_cpu) begin
                w_ldr_gnt = 1'b1;
            end else if (bus.cpu_req && bus.ldr_req) begin
                if (r_state == ST_CPU) begin
                    w_ldr_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b1;
                end
            end else begin
                w_cpu_gnt = bus.cpu_req;
                w_ldr_gnt = bus.ldr_req;
            end
        end
    end

    // Next owner state and read-return tag follow this cycle's grant.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_tag_nxt   = TAG_NONE;
        if (w_cpu_gnt) begin
            w_state_nxt = ST_CPU;
            w_tag_nxt   = TAG_CPU;
        end else if (w_ldr_gnt) begin
            w_state_nxt = bus.ldr_lock ? ST_LOCK : ST_LDR;
            w_tag_nxt   = bus.ldr_we ? TAG_NONE : TAG_LDR;
        end
    end

    // Owner state and tag registers.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            r_state <= ST_IDLE;
            r_tag   <= TAG_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    // Capture returning read data so it holds after the valid pulse.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (r_tag == TAG_CPU) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (r_tag == TAG_LDR) begin
                r_ldr_rdata <= bus.mem_rdata;
            end
        end
    end

    // Memory arrives one cycle after the strobe, so the valid cycle passes it
    // straight through; a reset in that cycle suppresses the return.
    assign w_cpu_rvalid   = (r_tag == TAG_CPU) & ~CLB;
    assign w_ldr_rvalid   = (r_tag == TAG_LDR) & ~CLB;
    assign w_mem_addr     = w_ldr_gnt ? bus.ldr_addr : bus.cpu_addr;

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.ldr_gnt    = w_ldr_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt & ~CLB;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.ldr_rvalid = w_ldr_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
    assign bus.ldr_rdata  = w_ldr_rvalid ? bus.mem_rdata : r_ldr_rdata;
    assign bus.mem_en     = w_cpu_gnt | w_ldr_gnt;
    assign bus.mem_we     = w_ldr_gnt & bus.ldr_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = bus.ldr_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_arbiter
// Brief   : Directed self-checking bench for imem_arbiter with a behavioural
//           256x8 synchronous memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic CLB = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    imem_arbiter_if #(.AW(8), .DW(8)) bus ();

    imem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
        .CLK (CLK),
        .CLB (CLB),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural memory: untouched locations return a fixed pattern.
    logic [7:0]   mem_arr [256];
    logic [255:0] wr_mask = '0;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        case (a)
            8'h05:   return 8'hA3;
            8'h20:   return 8'h5C;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_arr[bus.mem_addr] <= bus.mem_wdata;
                wr_mask[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= wr_mask[bus.mem_addr] ? mem_arr[bus.mem_addr]
                                                       : init_byte(bus.mem_addr);
            end
        end
    end

    task automatic drive_idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.ldr_req   = 1'b0;
        bus.ldr_we    = 1'b0;
        bus.ldr_lock  = 1'b0;
        bus.ldr_addr  = 8'h00;
        bus.ldr_wdata = 8'h00;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.cpu_req = 1'b1;
        bus.ldr_req = 1'b1;
        CLB = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            n_tests++; if (bus.cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_gnt: got %b want 0", bus.cpu_gnt); end
            n_tests++; if (bus.ldr_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ldr_gnt: got %b want 0", bus.ldr_gnt); end
            n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got en=%b we=%b want 0/0", bus.mem_en, bus.mem_we); end
            n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
        end
        n_tests++; if (bus.cpu_rvalid !== 1'b0 || bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got cpu=%b ldr=%b want 0/0", bus.cpu_rvalid, bus.ldr_rvalid); end
        n_tests++; if (bus.cpu_rdata !== 8'h00 || bus.ldr_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got cpu=%h ldr=%h want 00/00", bus.cpu_rdata, bus.ldr_rdata); end
    endtask

    task automatic test_cpu_only();
        @(negedge CLK);
        CLB = 1'b0;
        drive_idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h05;
        #1;
        n_tests++; if (bus.cpu_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0) begin n_fail++; $display("FAIL cpu_only_gnt: got cpu=%b ldr=%b want 1/0", bus.cpu_gnt, bus.ldr_gnt); end
        n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_only_stall: got %b want 0", bus.cpu_stall); end
        n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h05) begin n_fail++; $display("FAIL cpu_only_mem: got en=%b we=%b addr=%h want 1/0/05", bus.mem_en, bus.mem_we, bus.mem_addr); end
        @(negedge CLK);
        drive_idle();
        #1;
        n_tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA3) begin n_fail++; $display("FAIL cpu_only_rdata: got v=%b d=%h want 1/a3", bus.cpu_rvalid, bus.cpu_rdata); end
        n_tests++; if (bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_only_ldr_rvalid: got %b want 0", bus.ldr_rvalid); end
        @(negedge CLK); #1;
        n_tests++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'hA3) begin n_fail++; $display("FAIL cpu_only_hold: got v=%b d=%h want 0/a3", bus.cpu_rvalid, bus.cpu_rdata); end
    endtask

    task automatic test_round_robin();
        logic exp_cpu;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 8'h05;
            bus.ldr_req  = 1'b1;
            bus.ldr_we   = 1'b0;
            bus.ldr_lock = 1'b0;
            bus.ldr_addr = 8'h20;
            #1;
            exp_cpu = (i % 2 == 0);
            n_tests++; if (bus.cpu_gnt !== exp_cpu || bus.ldr_gnt !== !exp_cpu) begin n_fail++; $display("FAIL rr_gnt[%0d]: got cpu=%b ldr=%b want %b/%b", i, bus.cpu_gnt, bus.ldr_gnt, exp_cpu, !exp_cpu); end
            n_tests++; if (bus.cpu_stall !== !exp_cpu) begin n_fail++; $display("FAIL rr_stall[%0d]: got %b want %b", i, bus.cpu_stall, !exp_cpu); end
            if (i > 0) begin
                n_tests++;
                if (!exp_cpu) begin
                    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA3 || bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rr_ret[%0d]: got cv=%b cd=%h lv=%b want 1/a3/0", i, bus.cpu_rvalid, bus.cpu_rdata, bus.ldr_rvalid); end
                end else begin
                    if (bus.ldr_rvalid !== 1'b1 || bus.ldr_rdata !== 8'h5C || bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rr_ret[%0d]: got lv=%b ld=%h cv=%b want 1/5c/0", i, bus.ldr_rvalid, bus.ldr_rdata, bus.cpu_rvalid); end
                end
            end
        end
        @(negedge CLK);
        drive_idle();
        #1;
        n_tests++; if (bus.ldr_rvalid !== 1'b1 || bus.ldr_rdata !== 8'h5C) begin n_fail++; $display("FAIL rr_last_ret: got v=%b d=%h want 1/5c", bus.ldr_rvalid, bus.ldr_rdata); end
    endtask

    task automatic test_lock_burst();
        @(negedge CLK);
        drive_idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h12;
        #1;
        n_tests++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL burst_pre_gnt: got %b want 1", bus.cpu_gnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus.ldr_req   = 1'b1;
            bus.ldr_we    = 1'b1;
            bus.ldr_lock  = 1'b1;
            bus.ldr_addr  = 8'h10 + 8'(i);
            bus.ldr_wdata = 8'hD0 + 8'(i);
            #1;
            n_tests++; if (bus.ldr_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL burst_gnt[%0d]: got ldr=%b cpu=%b want 1/0", i, bus.ldr_gnt, bus.cpu_gnt); end
            n_tests++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL burst_stall[%0d]: got %b want 1", i, bus.cpu_stall); end
            n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL burst_mem[%0d]: got we=%b addr=%h want 1/%h", i, bus.mem_we, bus.mem_addr, 8'h10 + 8'(i)); end
            n_tests++; if (bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL burst_rvalid[%0d]: got %b want 0", i, bus.ldr_rvalid); end
        end
        @(negedge CLK);
        bus.ldr_req  = 1'b0;
        bus.ldr_we   = 1'b0;
        bus.ldr_lock = 1'b0;
        #1;
        n_tests++; if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL burst_release: got gnt=%b stall=%b want 1/0", bus.cpu_gnt, bus.cpu_stall); end
        n_tests++; if (bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL burst_wr_rvalid: got %b want 0", bus.ldr_rvalid); end
        @(negedge CLK);
        drive_idle();
        #1;
        n_tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hD2) begin n_fail++; $display("FAIL burst_readback: got v=%b d=%h want 1/d2", bus.cpu_rvalid, bus.cpu_rdata); end
    endtask

    task automatic test_starve_guard();
        logic exp_cpu;
        @(negedge CLK);
        drive_idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h05;
        #1;
        n_tests++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL guard_pre_gnt: got %b want 1", bus.cpu_gnt); end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            bus.ldr_req  = 1'b1;
            bus.ldr_we   = 1'b0;
            bus.ldr_lock = 1'b1;
            bus.ldr_addr = 8'h20;
            #1;
`ifdef IMEM_ARB_STARVE_GUARD_EN
            exp_cpu = (i == 4) || (i == 9);
`else
            exp_cpu = 1'b0;
`endif
            n_tests++; if (bus.cpu_gnt !== exp_cpu || bus.ldr_gnt !== !exp_cpu) begin n_fail++; $display("FAIL guard_gnt[%0d]: got cpu=%b ldr=%b want %b/%b", i, bus.cpu_gnt, bus.ldr_gnt, exp_cpu, !exp_cpu); end
            n_tests++; if (bus.cpu_stall !== !exp_cpu) begin n_fail++; $display("FAIL guard_stall[%0d]: got %b want %b", i, bus.cpu_stall, !exp_cpu); end
        end
        @(negedge CLK);
        drive_idle();
        @(negedge CLK);
    endtask

    task automatic test_reset_after_read();
        @(negedge CLK);
        drive_idle();
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 8'h20;
        #1;
        n_tests++; if (bus.ldr_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_rd_gnt: got %b want 1", bus.ldr_gnt); end
        @(negedge CLK);
        CLB = 1'b1;
        drive_idle();
        #1;
        n_tests++; if (bus.ldr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_suppress: got %b want 0", bus.ldr_rvalid); end
        @(negedge CLK);
        CLB = 1'b0;
        #1;
        n_tests++; if (bus.ldr_rvalid !== 1'b0 || bus.ldr_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rd_after: got v=%b d=%h want 0/00", bus.ldr_rvalid, bus.ldr_rdata); end
        n_tests++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_rd_state: got %0d want %0d", dut.r_state, ST_IDLE); end
        @(negedge CLK);
        bus.cpu_req = 1'b1;
        bus.ldr_req = 1'b1;
        #1;
        n_tests++; if (bus.cpu_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_rd_rearb: got cpu=%b ldr=%b want 1/0", bus.cpu_gnt, bus.ldr_gnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        test_reset();
        test_cpu_only();
        test_round_robin();
        test_lock_burst();
        test_starve_guard();
        test_reset_after_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
